pc_trap_unit: RTL and testbench
===============================

Name: pc_trap_unit

Overview:
- Parametrised successor to the OTTER program counter: PC register, next-PC select and increment, plus machine-mode trap/interrupt redirection.
- Holds an internal exception PC (EPC) and MRET return path, a pending-interrupt latch, a boot-hold cycle and a retired-update counter.
- Sits between the control unit/branch-address generator and instruction memory; drives the fetch address and PC+INC to the register-file write mux.

Parameters:
XLEN, 32, width of all address/target ports
RESET_VEC, 32'h0000_0000, PC value on reset
ILLEGAL_VEC, 32'h0000_0BAD, target for PC_SOURCE 110/111
INC, 4, increment added to PC
CNT_W, 16, width of RET_CNT

Ports:
CLK  in  1  clock, all state on rising edge
RST_N  in  1  asynchronous active-low reset
PC_WRITE  in  1  PC update enable (low = stall)
PC_SOURCE  in  3  next-PC select
JAL  in  XLEN  JAL target
BRANCH  in  XLEN  branch target
JALR  in  XLEN  JALR target
MTVEC  in  XLEN  trap vector base
INTR  in  1  external interrupt request, level or pulse
INTR_EN  in  1  global interrupt enable (mstatus.MIE)
PC_ADDRESS  out  XLEN  current PC
ADDR_INC_OUT  out  XLEN  PC_ADDRESS + INC, combinational
EPC  out  XLEN  saved exception PC
IN_TRAP  out  1  high while in TRAP state
INT_TAKEN  out  1  1-cycle pulse, cycle after interrupt accepted
PC_VALID  out  1  low during BOOT
RET_CNT  out  CNT_W  count of accepted PC updates
MISALIGN  out  1  1-cycle pulse on misaligned-target trap (see Optional Feature)

Behaviour:
- Reset: async assert on RST_N low. PC_ADDRESS=RESET_VEC, EPC=0, state=BOOT, pending=0, RET_CNT=0, INT_TAKEN=0, MISALIGN=0, IN_TRAP=0, PC_VALID=0.
- Deassertion takes effect on the next CLK edge. Reset mid-trap discards EPC and pending.
- Select mux, combinational:
  - 000: EPC (MRET)
  - 001: MTVEC (synchronous trap)
  - 010: JAL
  - 011: BRANCH
  - 100: {JALR[XLEN-1:1],1'b0}
  - 101: PC+INC
  - 110/111: ILLEGAL_VEC
- Adder wraps modulo 2^XLEN; no carry out.
- FSM states BOOT, RUN, TRAP:
  - BOOT: lasts exactly 1 cycle after reset release. PC held, PC_WRITE ignored, INTR sampled into pending. Always goes to RUN.
  - RUN, PC_WRITE=0: everything holds, including pending.
  - RUN, PC_WRITE=1 with PC_SOURCE=001: EPC<=PC_ADDRESS, PC<=MTVEC, go to TRAP.
  - RUN, PC_WRITE=1 with (INTR|pending)&INTR_EN and PC_SOURCE!=001: EPC<=mux output, PC<=MTVEC, pending<=0, INT_TAKEN=1 next cycle, go to TRAP.
  - RUN, PC_WRITE=1 with PC_SOURCE=000: PC<=EPC, stay in RUN.
  - RUN, PC_WRITE=1 otherwise: PC<=mux output.
  - TRAP: normal updates. Interrupts never taken; an INTR seen sets pending. PC_SOURCE=001 overwrites EPC with PC_ADDRESS, PC<=MTVEC, stay in TRAP. PC_SOURCE=000 with PC_WRITE: PC<=EPC, go to RUN.
  - TRAP return: a pending interrupt is taken on the first PC_WRITE in RUN after return, not the return cycle itself.
- Simultaneous synchronous trap and interrupt: synchronous trap wins; interrupt is latched as pending.
- INTR while INTR_EN=0: latched in pending, taken once INTR_EN=1.
- RET_CNT increments on every cycle PC_ADDRESS is written in RUN/TRAP, traps included. Wraps to 0 after all-ones.

Optional Feature:
- Macro PC_MISALIGN_EN.
- Defined:
  - In RUN/TRAP with PC_WRITE=1, a non-trap target (PC_SOURCE not 001) with bits [1:0]!=0 is treated as a synchronous trap: EPC<=PC_ADDRESS, PC<=MTVEC, go to TRAP, MISALIGN pulses 1 cycle.
  - This outranks the interrupt; the interrupt becomes pending.
- Undefined: target loaded as-is; MISALIGN tied 0.

Test Plan:
- Reset/boot: RST_N low mid-run, release -> PC=0, PC_VALID=0 for 1 cycle, then PC_SOURCE=101 with writes gives 0,4,8; RET_CNT=2 after two writes.
- Branch/jump select: PC=0x10, JALR=0x203 with src 100 -> PC=0x202. BRANCH=0x40 with src 011 -> 0x40. Src 110 -> 0xBAD. PC_WRITE=0 -> PC holds.
- Interrupt entry/return: PC=0x20, src 101, INTR=1, INTR_EN=1, MTVEC=0x100 -> PC=0x100, EPC=0x24, INT_TAKEN pulse, IN_TRAP=1. Src 000 -> PC=0x24, IN_TRAP=0.
- Collision: PC=0x30, src 001 and INTR same cycle -> EPC=0x30, PC=MTVEC. INTR is held pending; after MRET the first write -> PC=MTVEC, EPC=return target.
- Masking: INTR pulse with INTR_EN=0 -> no redirect. Raise INTR_EN later -> trap on the next PC_WRITE.
- PC_MISALIGN_EN: PC=0x50, JAL=0x62, src 010 -> PC=MTVEC, EPC=0x50, MISALIGN pulse. Without the macro -> PC=0x62.

Source files
------------

// File: rtl/pc_trap_unit_if.sv
// Bus between control unit / branch-address generator and pc_trap_unit.
// master = control side driving selects and targets, slave = PC/trap unit.
interface pc_trap_unit_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic             PC_WRITE;
  logic [2:0]       PC_SOURCE;
  logic [XLEN-1:0]  JAL;
  logic [XLEN-1:0]  BRANCH;
  logic [XLEN-1:0]  JALR;
  logic [XLEN-1:0]  MTVEC;
  logic             INTR;
  logic             INTR_EN;
  logic [XLEN-1:0]  PC_ADDRESS;
  logic [XLEN-1:0]  ADDR_INC_OUT;
  logic [XLEN-1:0]  EPC;
  logic             IN_TRAP;
  logic             INT_TAKEN;
  logic             PC_VALID;
  logic [CNT_W-1:0] RET_CNT;
  logic             MISALIGN;

  modport master (
    output PC_WRITE, PC_SOURCE, JAL, BRANCH, JALR, MTVEC, INTR, INTR_EN,
    input  PC_ADDRESS, ADDR_INC_OUT, EPC, IN_TRAP, INT_TAKEN, PC_VALID,
           RET_CNT, MISALIGN
  );

  modport slave (
    input  PC_WRITE, PC_SOURCE, JAL, BRANCH, JALR, MTVEC, INTR, INTR_EN,
    output PC_ADDRESS, ADDR_INC_OUT, EPC, IN_TRAP, INT_TAKEN, PC_VALID,
           RET_CNT, MISALIGN
  );
endinterface

// File: rtl/pc_trap_unit.sv
// Program counter with next-PC select, machine-mode trap/interrupt entry and MRET.
// Optional macro PC_MISALIGN_EN turns misaligned non-trap targets into synchronous traps.
module pc_trap_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [XLEN-1:0] ILLEGAL_VEC = 32'h0000_0BAD,
  parameter int              INC         = 4,
  parameter int              CNT_W       = 16
) (
  input logic           CLK,
  input logic           RST_N,
  pc_trap_unit_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  epc_q;
  logic [XLEN-1:0]  pc_inc;
  logic [XLEN-1:0]  mux_out;
  logic             pending_q;
  logic             pending_d;
  logic [CNT_W-1:0] ret_cnt_q;
  logic             int_taken_q;

  logic             write_en;
  logic             misalign_hit;
  logic             sync_trap;
  logic             intr_req;
  logic             take_int;
  logic             mret_exit;

  assign pc_inc = pc_q + XLEN'(INC);

  always_comb begin
    mux_out = pc_inc;
    case (bus.PC_SOURCE)
      3'b000:  mux_out = epc_q;
      3'b001:  mux_out = bus.MTVEC;
      3'b010:  mux_out = bus.JAL;
      3'b011:  mux_out = bus.BRANCH;
      3'b100:  mux_out = {bus.JALR[XLEN-1:1], 1'b0};
      3'b101:  mux_out = pc_inc;
      default: mux_out = ILLEGAL_VEC;
    endcase
  end

  // A synchronous trap (explicit or misalignment) always outranks the interrupt.
  always_comb begin
    write_en = bus.PC_WRITE && (state_q != BOOT);
`ifdef PC_MISALIGN_EN
    misalign_hit = write_en && (bus.PC_SOURCE != 3'b001) && (mux_out[1:0] != 2'b00);
`else
    misalign_hit = 1'b0;
`endif
    sync_trap = write_en && ((bus.PC_SOURCE == 3'b001) || misalign_hit);
    intr_req  = (bus.INTR || pending_q) && bus.INTR_EN;
    take_int  = write_en && (state_q == RUN) && !sync_trap && intr_req;
    mret_exit = write_en && (state_q == TRAP) && !sync_trap && (bus.PC_SOURCE == 3'b000);
  end

  always_comb begin
    pending_d = pending_q;
    case (state_q)
      BOOT: pending_d = pending_q | bus.INTR;
      RUN: begin
        if (take_int) begin
          pending_d = 1'b0;
        end else if (write_en) begin
          pending_d = pending_q | bus.INTR;
        end
      end
      TRAP:    pending_d = pending_q | bus.INTR;
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (sync_trap || take_int) begin
          state_d = TRAP;
        end
      end
      TRAP: begin
        if (mret_exit) begin
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    bus.IN_TRAP  = (state_q == TRAP);
    bus.PC_VALID = (state_q != BOOT);
  end

  // Trap entry saves the faulting PC; interrupt entry saves where execution would have gone.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q        <= RESET_VEC;
      epc_q       <= '0;
      pending_q   <= 1'b0;
      ret_cnt_q   <= '0;
      int_taken_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      int_taken_q <= take_int;
      if (write_en) begin
        ret_cnt_q <= ret_cnt_q + 1'b1;
        if (sync_trap) begin
          epc_q <= pc_q;
          pc_q  <= bus.MTVEC;
        end else if (take_int) begin
          epc_q <= mux_out;
          pc_q  <= bus.MTVEC;
        end else begin
          pc_q  <= mux_out;
        end
      end
    end
  end

`ifdef PC_MISALIGN_EN
  logic misalign_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_hit;
    end
  end

  assign bus.MISALIGN = misalign_q;
`else
  assign bus.MISALIGN = 1'b0;
`endif

  assign bus.PC_ADDRESS   = pc_q;
  assign bus.ADDR_INC_OUT = pc_inc;
  assign bus.EPC          = epc_q;
  assign bus.INT_TAKEN    = int_taken_q;
  assign bus.RET_CNT      = ret_cnt_q;

endmodule

// File: tb/tb_pc_trap_unit.sv
// Self-checking bench for pc_trap_unit: directed vector table, corner sequences,
// then randomized traffic against a behavioural model of the trap rules.
module tb_pc_trap_unit;

  localparam int          XLEN  = 32;
  localparam int          CNT_W = 16;
  localparam logic [31:0] MTV   = 32'h0000_0100;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  int   checks = 0;
  int   passed = 0;

  pc_trap_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  pc_trap_unit #(
    .XLEN(XLEN), .RESET_VEC(32'h0000_0000), .ILLEGAL_VEC(32'h0000_0BAD),
    .INC(4), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [2:0]  src;
    logic [31:0] tgt;
    logic        intr;
    logic        en;
    logic [31:0] exp_pc;
    logic [31:0] exp_epc;
    logic        exp_trap;
    logic        exp_it;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic wr, logic [2:0] src, logic [31:0] tgt, logic intr,
                              logic en, logic [31:0] pc, logic [31:0] epc, logic trap,
                              logic it, logic [15:0] cnt);
    vec_t v;
    v.wr = wr; v.src = src; v.tgt = tgt; v.intr = intr; v.en = en;
    v.exp_pc = pc; v.exp_epc = epc; v.exp_trap = trap; v.exp_it = it; v.exp_cnt = cnt;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else begin
      passed++;
    end
  endtask

  task automatic checkOutput(input logic [31:0] pc, input logic [31:0] epc, input logic trap,
                             input logic it, input logic valid, input logic [15:0] cnt,
                             input logic mis);
    checkValue("pc", bus.PC_ADDRESS, pc);
    checkValue("addr_inc", bus.ADDR_INC_OUT, pc + 32'd4);
    checkValue("epc", bus.EPC, epc);
    checkValue("in_trap", 32'(bus.IN_TRAP), 32'(trap));
    checkValue("int_taken", 32'(bus.INT_TAKEN), 32'(it));
    checkValue("pc_valid", 32'(bus.PC_VALID), 32'(valid));
    checkValue("ret_cnt", 32'(bus.RET_CNT), 32'(cnt));
    checkValue("misalign", 32'(bus.MISALIGN), 32'(mis));
  endtask

  task automatic applyStimulus(input logic wr, input logic [2:0] src, input logic [31:0] jal,
                               input logic [31:0] br, input logic [31:0] jalr,
                               input logic [31:0] mtvec, input logic intr, input logic en);
    bus.PC_WRITE  = wr;
    bus.PC_SOURCE = src;
    bus.JAL       = jal;
    bus.BRANCH    = br;
    bus.JALR      = jalr;
    bus.MTVEC     = mtvec;
    bus.INTR      = intr;
    bus.INTR_EN   = en;
    @(posedge CLK);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the reset state, then releases so the next edge is BOOT.
  task automatic doReset();
    #2;
    RST_N = 1'b0;
    bus.INTR = 1'b0;
    #1;
    checkOutput(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    #1;
    checkValue("boot_valid", 32'(bus.PC_VALID), 32'd0);
  endtask

  // Behavioural reference: architectural PC/EPC, pending flag and mode tracked directly.
  logic [31:0] m_pc, m_epc;
  logic        m_pend, m_it, m_mis;
  logic [15:0] m_cnt;
  int          m_mode;

  task automatic modelReset();
    m_pc = 32'h0; m_epc = 32'h0; m_pend = 1'b0; m_cnt = 16'd0;
    m_it = 1'b0; m_mis = 1'b0; m_mode = 0;
  endtask

  task automatic modelStep(input logic wr, input logic [2:0] src, input logic [31:0] jal,
                           input logic [31:0] br, input logic [31:0] jalr,
                           input logic [31:0] mtvec, input logic intr, input logic en);
    logic [31:0] target;
    logic        bad;
    case (src)
      3'd0:    target = m_epc;
      3'd1:    target = mtvec;
      3'd2:    target = jal;
      3'd3:    target = br;
      3'd4:    target = jalr & 32'hFFFF_FFFE;
      3'd5:    target = m_pc + 32'd4;
      default: target = 32'h0000_0BAD;
    endcase
    m_it  = 1'b0;
    m_mis = 1'b0;
    if (m_mode == 0) begin
      m_pend = m_pend | intr;
      m_mode = 1;
    end else if (!wr) begin
      if (m_mode == 2) m_pend = m_pend | intr;
    end else begin
      m_cnt = m_cnt + 16'd1;
`ifdef PC_MISALIGN_EN
      bad = (src != 3'd1) && (target % 4 != 0);
`else
      bad = 1'b0;
`endif
      if (src == 3'd1 || bad) begin
        m_epc  = m_pc;
        m_pc   = mtvec;
        m_mode = 2;
        m_pend = m_pend | intr;
        m_mis  = bad;
      end else if (m_mode == 1 && (intr || m_pend) && en) begin
        m_epc  = target;
        m_pc   = mtvec;
        m_mode = 2;
        m_pend = 1'b0;
        m_it   = 1'b1;
      end else begin
        m_pc   = target;
        m_pend = m_pend | intr;
        if (src == 3'd0 && m_mode == 2) m_mode = 1;
      end
    end
  endtask

  function automatic logic [31:0] randTarget();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 3) != 0) v[1:0] = 2'b00;
    return v;
  endfunction

  initial begin
    bus.PC_WRITE = 1'b0; bus.PC_SOURCE = 3'd0; bus.JAL = '0; bus.BRANCH = '0;
    bus.JALR = '0; bus.MTVEC = MTV; bus.INTR = 1'b0; bus.INTR_EN = 1'b0;

    vecs[0]  = mk(1, 5, 32'h000, 0, 0, 32'h004, 32'h000, 0, 0, 1);
    vecs[1]  = mk(1, 5, 32'h000, 0, 0, 32'h008, 32'h000, 0, 0, 2);
    vecs[2]  = mk(1, 2, 32'h010, 0, 0, 32'h010, 32'h000, 0, 0, 3);
    vecs[3]  = mk(1, 4, 32'h205, 0, 0, 32'h204, 32'h000, 0, 0, 4);
    vecs[4]  = mk(1, 3, 32'h040, 0, 0, 32'h040, 32'h000, 0, 0, 5);
    vecs[5]  = mk(0, 5, 32'h080, 0, 0, 32'h040, 32'h000, 0, 0, 5);
    vecs[6]  = mk(1, 2, 32'h020, 0, 0, 32'h020, 32'h000, 0, 0, 6);
    vecs[7]  = mk(1, 5, 32'h000, 1, 1, 32'h100, 32'h024, 1, 1, 7);
    vecs[8]  = mk(1, 5, 32'h000, 0, 1, 32'h104, 32'h024, 1, 0, 8);
    vecs[9]  = mk(1, 0, 32'h000, 0, 1, 32'h024, 32'h024, 0, 0, 9);
    vecs[10] = mk(1, 2, 32'h030, 0, 0, 32'h030, 32'h024, 0, 0, 10);
    vecs[11] = mk(1, 1, 32'h030, 1, 1, 32'h100, 32'h030, 1, 0, 11);
    vecs[12] = mk(1, 0, 32'h000, 0, 0, 32'h030, 32'h030, 0, 0, 12);
    vecs[13] = mk(1, 5, 32'h000, 0, 1, 32'h100, 32'h034, 1, 1, 13);
    vecs[14] = mk(1, 0, 32'h000, 0, 0, 32'h034, 32'h034, 0, 0, 14);
    vecs[15] = mk(1, 5, 32'h000, 1, 0, 32'h038, 32'h034, 0, 0, 15);
    vecs[16] = mk(1, 5, 32'h000, 0, 0, 32'h03C, 32'h034, 0, 0, 16);
    vecs[17] = mk(0, 5, 32'h000, 0, 1, 32'h03C, 32'h034, 0, 0, 16);
    vecs[18] = mk(1, 5, 32'h000, 0, 1, 32'h100, 32'h040, 1, 1, 17);
    vecs[19] = mk(1, 1, 32'h000, 0, 0, 32'h100, 32'h100, 1, 0, 18);
    vecs[20] = mk(1, 0, 32'h000, 0, 0, 32'h100, 32'h100, 0, 0, 19);

    doReset();
    applyStimulus(1, 5, 0, 0, 0, MTV, 0, 0);
    checkOutput(32'h0, 32'h0, 0, 0, 1, 16'd0, 0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].src, vecs[i].tgt, vecs[i].tgt, vecs[i].tgt, MTV,
                    vecs[i].intr, vecs[i].en);
      checkOutput(vecs[i].exp_pc, vecs[i].exp_epc, vecs[i].exp_trap, vecs[i].exp_it, 1,
                  vecs[i].exp_cnt, 0);
    end

    // Misaligned targets, illegal select and adder wrap.
    applyStimulus(1, 2, 32'h50, 32'h50, 32'h50, MTV, 0, 0);
    checkOutput(32'h50, 32'h100, 0, 0, 1, 16'd20, 0);
    applyStimulus(1, 2, 32'h62, 32'h62, 32'h62, MTV, 0, 0);
`ifdef PC_MISALIGN_EN
    checkOutput(32'h100, 32'h50, 1, 0, 1, 16'd21, 1);
`else
    checkOutput(32'h62, 32'h100, 0, 0, 1, 16'd21, 0);
`endif
    applyStimulus(1, 6, 32'h0, 32'h0, 32'h0, MTV, 0, 0);
`ifdef PC_MISALIGN_EN
    checkOutput(32'h100, 32'h100, 1, 0, 1, 16'd22, 1);
`else
    checkOutput(32'hBAD, 32'h100, 0, 0, 1, 16'd22, 0);
`endif
    applyStimulus(1, 4, 32'h203, 32'h203, 32'h203, MTV, 0, 0);
`ifdef PC_MISALIGN_EN
    checkOutput(32'h100, 32'h100, 1, 0, 1, 16'd23, 1);
    applyStimulus(0, 5, 0, 0, 0, MTV, 0, 0);
    checkOutput(32'h100, 32'h100, 1, 0, 1, 16'd23, 0);
`else
    checkOutput(32'h202, 32'h100, 0, 0, 1, 16'd23, 0);
    applyStimulus(0, 5, 0, 0, 0, MTV, 0, 0);
    checkOutput(32'h202, 32'h100, 0, 0, 1, 16'd23, 0);
`endif
    applyStimulus(1, 2, 32'hFFFF_FFFC, 32'h0, 32'h0, MTV, 0, 0);
`ifdef PC_MISALIGN_EN
    checkOutput(32'hFFFF_FFFC, 32'h100, 1, 0, 1, 16'd24, 0);
    applyStimulus(1, 5, 0, 0, 0, MTV, 0, 0);
    checkOutput(32'h0, 32'h100, 1, 0, 1, 16'd25, 0);
`else
    checkOutput(32'hFFFF_FFFC, 32'h100, 0, 0, 1, 16'd24, 0);
    applyStimulus(1, 5, 0, 0, 0, MTV, 0, 0);
    checkOutput(32'h0, 32'h100, 0, 0, 1, 16'd25, 0);
`endif

    // Reset while trapped with an interrupt pending must discard both.
    applyStimulus(1, 1, 0, 0, 0, MTV, 1, 0);
    checkOutput(32'h100, 32'h0, 1, 0, 1, 16'd26, 0);
    doReset();
    applyStimulus(1, 5, 0, 0, 0, MTV, 0, 1);
    checkOutput(32'h0, 32'h0, 0, 0, 1, 16'd0, 0);
    applyStimulus(1, 5, 0, 0, 0, MTV, 0, 1);
    checkOutput(32'h4, 32'h0, 0, 0, 1, 16'd1, 0);
    applyStimulus(1, 5, 0, 0, 0, MTV, 0, 1);
    checkOutput(32'h8, 32'h0, 0, 0, 1, 16'd2, 0);

    doReset();
    modelReset();
    for (int n = 0; n < 600; n++) begin
      logic        wr, intr, en;
      logic [2:0]  src;
      logic [31:0] jal, br, jalr, mtvec;
      wr    = ($urandom_range(0, 4) != 0);
      src   = 3'($urandom_range(0, 7));
      intr  = ($urandom_range(0, 5) == 0);
      en    = ($urandom_range(0, 1) == 1);
      jal   = randTarget();
      br    = randTarget();
      jalr  = randTarget();
      mtvec = $urandom & 32'hFFFF_FFFC;
      applyStimulus(wr, src, jal, br, jalr, mtvec, intr, en);
      modelStep(wr, src, jal, br, jalr, mtvec, intr, en);
      checkOutput(m_pc, m_epc, (m_mode == 2), m_it, (m_mode != 0), m_cnt, m_mis);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
